// File: rtl/div_unit_pkg.sv
// Shared constants for the execute-stage divider: op codes, default width, FSM states.
package div_unit_pkg;

  localparam int unsigned DIV_DATA_W = 32;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_BUSY = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// E-stage <-> divider signal bundle; the pipeline side is master, the divider is slave.
interface div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic [7:0]        alucontrol;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              flush;
  logic              stallE;
  logic              div_stall;
  logic              ready;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output alucontrol, a, b, flush, stallE,
    input  div_stall, ready, hi, lo
  );

  modport slave (
    input  alucontrol, a, b, flush, stallE,
    output div_stall, ready, hi, lo
  );
endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract on no borrow.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] q_in,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W:0]   rem_out,
  output logic [DATA_W-1:0] q_out
);

  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] trial;
  logic              borrow;

  always_comb begin
    shifted = {rem_in, q_in[DATA_W-1]};
    trial   = shifted - {2'b00, d};
    borrow  = trial[DATA_W+1];
    rem_out = borrow ? shifted[DATA_W:0] : trial[DATA_W:0];
    q_out   = {q_in[DATA_W-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU engine: {hi,lo} = {remainder,quotient}, stalls F..E while iterating.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              start;
  logic              signed_op;
  logic              ready;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   step_rem;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] q_fix, r_fix;

  assign start     = is_div_op(bus.alucontrol) && !bus.flush;
  assign signed_op = (bus.alucontrol == EXE_DIV_OP);
  assign ready     = (state_q == DIV_DONE) && !bus.flush;

  assign bus.ready     = ready;
  assign bus.div_stall = start && !ready;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in (rem_q),
    .q_in   (quo_q),
    .d      (dvs_q),
    .rem_out(step_rem),
    .q_out  (step_q)
  );

  always_comb begin
    // two's-complement negate leaves the most negative value unchanged, which is its magnitude
    a_abs = (signed_op && bus.a[DATA_W-1]) ? -bus.a : bus.a;
    b_abs = (signed_op && bus.b[DATA_W-1]) ? -bus.b : bus.b;
    q_fix = (sa_q ^ sb_q) ? -step_q : step_q;
    r_fix = sa_q ? -step_rem[DATA_W-1:0] : step_rem[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (bus.flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            sa_d    = signed_op && bus.a[DATA_W-1];
            sb_d    = signed_op && bus.b[DATA_W-1];
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            cnt_d   = '0;
            state_d = (bus.b == '0) ? DIV_ZERO : DIV_BUSY;
          end
        end
        DIV_ZERO: begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = DIV_DONE;
        end
        DIV_BUSY: begin
          rem_d = step_rem;
          quo_d = step_q;
          cnt_d = cnt_q + 1'b1;
          // the final step's result goes straight through sign fix-up into hi/lo
          if (cnt_q == CNT_LAST) begin
            hi_d    = r_fix;
            lo_d    = q_fix;
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!bus.stallE) state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected {hi,lo} queued at issue, checked by an independent monitor.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam logic [7:0] NOP = 8'h00;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] exp_q[$];

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // consumption point: result is taken when ready and the E stage is not held
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && bus.ready && !bus.stallE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("hi", bus.hi, e[63:32]);
          check("lo", bus.lo, e[31:0]);
        end
      end
    end
  end

  // caller is always positioned 1 time unit after a rising edge
  task automatic do_div(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input int elat,
                        input int hold, input bit nop_after);
    int n;
    int stalls;
    n = 0;
    stalls = 0;
    exp_q.push_back({eh, el});
    bus.alucontrol = op;
    bus.a = av;
    bus.b = bv;
    bus.stallE = (hold > 0);
    forever begin
      @(negedge clk);
      n++;
      if (bus.div_stall) stalls++;
      if (bus.ready) break;
      if (n >= 100) break;
    end
    check("latency", n, elat);
    check("stall_cycles", stalls, elat - 1);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_ready", {31'd0, bus.ready}, 32'd1);
        check("hold_hi", bus.hi, eh);
        check("hold_lo", bus.lo, el);
        check("hold_stall", {31'd0, bus.div_stall}, 32'd0);
      end
      @(posedge clk);
      #1 bus.stallE = 1'b0;
    end
    @(posedge clk);
    #1;
    if (nop_after) bus.alucontrol = NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alucontrol = NOP;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;
    bus.stallE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_stall", {31'd0, bus.div_stall}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    do_div(EXE_DIV_OP,  32'd7,        32'd2,        32'd1,        32'd3,        34, 0, 1);
    do_div(EXE_DIV_OP,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 0, 1);

    // flush in the 10th BUSY cycle
    bus.alucontrol = EXE_DIV_OP;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    check("flush_ready", {31'd0, bus.ready}, 32'd0);
    check("flush_stall", {31'd0, bus.div_stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.alucontrol = NOP;
    @(negedge clk);
    check("post_flush_ready", {31'd0, bus.ready}, 32'd0);
    check("post_flush_hi", bus.hi, 32'hFFFFFFFF);
    check("post_flush_lo", bus.lo, 32'hFFFFFFFD);
    @(posedge clk);
    #1;

    do_div(EXE_DIVU_OP, 32'd100,      32'd7,        32'd2,        32'd14,       34, 0, 1);
    do_div(EXE_DIVU_OP, 32'hFFFFFFFF, 32'd2,        32'd1,        32'h7FFFFFFF, 34, 0, 1);
    do_div(EXE_DIV_OP,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 34, 0, 1);
    do_div(EXE_DIV_OP,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 34, 0, 1);
    do_div(EXE_DIV_OP,  32'd5,        32'd0,        32'd0,        32'd0,        3,  0, 1);
    // held result, then an identical DIV issued back to back
    do_div(EXE_DIV_OP,  32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 34, 5, 0);
    do_div(EXE_DIV_OP,  32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 34, 0, 1);

    // reset in the middle of an iteration
    bus.alucontrol = EXE_DIVU_OP;
    bus.a = 32'd55;
    bus.b = 32'd4;
    repeat (6) @(posedge clk);
    #3;
    resetn = 1'b0;
    bus.alucontrol = NOP;
    #1;
    check("midrst_ready", {31'd0, bus.ready}, 32'd0);
    check("midrst_stall", {31'd0, bus.div_stall}, 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    do_div(EXE_DIVU_OP, 32'd55,       32'd4,        32'd3,        32'd13,       34, 0, 1);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
